// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer and its next-PC selector.
package pc_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_TRAP = 3'd1,
        SEL_ERET = 3'd2,
        SEL_BR   = 3'd3,
        SEL_J    = 3'd4,
        SEL_JAL  = 3'd5,
        SEL_JR   = 3'd6
    } sel_e;

    localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0020;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC priority select and target arithmetic; word-addressed PC.
module next_pc_calc
    import pc_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(DEFAULT_TRAP_VEC)
) (
    input  logic [PC_W-1:0] pc_i,
    input  logic [25:0]     jidx_i,
    input  logic            trap_i,
    input  logic            eret_i,
    input  logic            branch_taken_i,
    input  logic            jump_i,
    input  logic            jal_i,
    input  logic            jr_i,
    input  logic [31:0]     imm_ext_i,
    input  logic [PC_W-1:0] jr_target_i,
    input  logic [PC_W-1:0] epc_i,
    output logic [PC_W-1:0] next_pc_o,
    output logic [PC_W-1:0] pc_plus1_o,
    output logic [2:0]      sel_o
);

    logic [PC_W-1:0] p1;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] j_target;
    sel_e            sel;

    assign p1        = pc_i + PC_W'(1);
    assign br_target = p1 + imm_ext_i[PC_W-1:0];
    // Region bits come from pc+1, not pc, matching MIPS jump semantics.
    assign j_target  = {p1[PC_W-1:26], jidx_i};

    always_comb begin
        sel       = SEL_SEQ;
        next_pc_o = p1;
        if (trap_i) begin
            sel       = SEL_TRAP;
            next_pc_o = TRAP_VEC;
        end else if (eret_i) begin
            sel       = SEL_ERET;
            next_pc_o = epc_i;
        end else if (branch_taken_i) begin
            sel       = SEL_BR;
            next_pc_o = br_target;
        end else if (jump_i) begin
            sel       = SEL_J;
            next_pc_o = j_target;
        end else if (jal_i) begin
            sel       = SEL_JAL;
            next_pc_o = j_target;
        end else if (jr_i) begin
            sel       = SEL_JR;
            next_pc_o = jr_target_i;
        end
    end

    assign pc_plus1_o = p1;
    assign sel_o      = sel;

endmodule

// File: rtl/pc_sequencer.sv
// PC and fetch sequencer: FETCH/ISSUE handshake, jal link strobe, trap/eret EPC, retired count.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(DEFAULT_TRAP_VEC),
    parameter int              CNT_W    = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    output logic             imem_req_o,
    output logic [PC_W-1:0]  imem_addr_o,
    input  logic             imem_ready_i,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    input  logic             exec_done_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             jal_i,
    input  logic             jr_i,
    input  logic             trap_i,
    input  logic             eret_i,
    input  logic [31:0]      imm_ext_i,
    input  logic [PC_W-1:0]  jr_target_i,
    output logic [PC_W-1:0]  pc_o,
    output logic             link_we_o,
    output logic [PC_W-1:0]  link_data_o,
    output logic [PC_W-1:0]  epc_o,
    output logic [CNT_W-1:0] retired_o
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [PC_W-1:0]  epc_q, epc_d;
    logic [PC_W-1:0]  link_data_q, link_data_d;
    logic             link_we_q, link_we_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic             imem_req;
    logic             instr_valid;
    logic [PC_W-1:0]  next_pc;
    logic [PC_W-1:0]  pc_plus1;
    logic [2:0]       sel;

    next_pc_calc #(
        .PC_W     (PC_W),
        .TRAP_VEC (TRAP_VEC)
    ) u_next_pc_calc (
        .pc_i           (pc_q),
        .jidx_i         (instr_q[25:0]),
        .trap_i         (trap_i),
        .eret_i         (eret_i),
        .branch_taken_i (branch_taken_i),
        .jump_i         (jump_i),
        .jal_i          (jal_i),
        .jr_i           (jr_i),
        .imm_ext_i      (imm_ext_i),
        .jr_target_i    (jr_target_i),
        .epc_i          (epc_q),
        .next_pc_o      (next_pc),
        .pc_plus1_o     (pc_plus1),
        .sel_o          (sel)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        epc_d       = epc_q;
        link_data_d = link_data_q;
        link_we_d   = 1'b0;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready_i) begin
                    instr_d = imem_data_i;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (exec_done_i) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                    // A trapped instruction did not complete, so it is not counted.
                    if (sel == SEL_TRAP) begin
                        epc_d = pc_q;
                    end else begin
                        retired_d = retired_q + CNT_W'(1);
                    end
                    if (sel == SEL_JAL) begin
                        link_data_d = pc_plus1;
                        link_we_d   = 1'b1;
                    end
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= '0;
            epc_q       <= '0;
            link_data_q <= '0;
            link_we_q   <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            epc_q       <= epc_d;
            link_data_q <= link_data_d;
            link_we_q   <= link_we_d;
            retired_q   <= retired_d;
        end
    end

    // Request and valid are masked while reset is held so memory sees no fetch in that cycle.
    assign imem_req_o    = imem_req & ~reset_i;
    assign instr_valid_o = instr_valid & ~reset_i;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign link_we_o     = link_we_q;
    assign link_data_o   = link_data_q;
    assign epc_o         = epc_q;
    assign retired_o     = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        branch_taken;
    logic        jump;
    logic        jal;
    logic        jr;
    logic        trap;
    logic        eret;
    logic [31:0] imm_ext;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic        link_we;
    logic [31:0] link_data;
    logic [31:0] epc;
    logic [31:0] retired;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    pc_sequencer dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ready_i   (imem_ready),
        .imem_data_i    (imem_data),
        .instr_o        (instr),
        .instr_valid_o  (instr_valid),
        .exec_done_i    (exec_done),
        .branch_taken_i (branch_taken),
        .jump_i         (jump),
        .jal_i          (jal),
        .jr_i           (jr),
        .trap_i         (trap),
        .eret_i         (eret),
        .imm_ext_i      (imm_ext),
        .jr_target_i    (jr_target),
        .pc_o           (pc),
        .link_we_o      (link_we),
        .link_data_o    (link_data),
        .epc_o          (epc),
        .retired_o      (retired)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctl();
        exec_done    = 1'b0;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jal          = 1'b0;
        jr           = 1'b0;
        trap         = 1'b0;
        eret         = 1'b0;
        imm_ext      = '0;
        jr_target    = '0;
    endtask

    // One FETCH cycle with immediate ready; leaves the DUT in ISSUE.
    task automatic fetch(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_data  = word;
        tick();
        imem_ready = 1'b0;
        imem_data  = '0;
    endtask

    // One ISSUE cycle with exec_done and whatever controls the caller set; back in FETCH.
    task automatic issue();
        exec_done = 1'b1;
        tick();
        clear_ctl();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_data  = '0;
        clear_ctl();
        tick();
        tick();
        check("rst_req", imem_req, 0);
        check("rst_pc", pc, 0);
        check("rst_instr", instr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_link_we", link_we, 0);
        check("rst_link_data", link_data, 0);
        check("rst_epc", epc, 0);
        check("rst_retired", retired, 0);
        reset = 1'b0;
        #1;
        check("first_req", imem_req, 1);

        // Sequential fetch
        for (int i = 0; i < 3; i++) begin
            check($sformatf("seq_pc%0d", i), pc, 64'(i));
            check($sformatf("seq_addr%0d", i), imem_addr, 64'(i));
            check($sformatf("seq_req_f%0d", i), imem_req, 1);
            fetch(32'h1000_0000 + 32'(i));
            check($sformatf("seq_req_i%0d", i), imem_req, 0);
            check($sformatf("seq_valid%0d", i), instr_valid, 1);
            check($sformatf("seq_instr%0d", i), instr, 64'(32'h1000_0000 + 32'(i)));
            issue();
        end
        check("seq_pc3", pc, 3);
        check("seq_retired", retired, 3);

        // Fetch wait, then reset with imem_ready high
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("wait_req%0d", i), imem_req, 1);
            check($sformatf("wait_valid%0d", i), instr_valid, 0);
        end
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_data  = 32'hDEAD_BEEF;
        #1;
        check("rstcyc_req", imem_req, 0);
        tick();
        imem_ready = 1'b0;
        imem_data  = '0;
        reset      = 1'b0;
        #1;
        check("rstcyc_instr", instr, 0);
        check("rstcyc_pc", pc, 0);
        check("rstcyc_valid", instr_valid, 0);
        check("rstcyc_fetch", imem_req, 1);

        // Branch back with wrap: pc 2, imm -4 -> 3 - 4 = 0xFFFFFFFF
        fetch(32'h0); issue();
        fetch(32'h0); issue();
        check("br_pc2", pc, 2);
        fetch(32'h1000_FFFC);
        branch_taken = 1'b1;
        imm_ext      = 32'hFFFF_FFFC;
        issue();
        check("br_wrap", pc, 32'hFFFF_FFFF);
        fetch(32'h0); issue();
        check("seq_wrap", pc, 0);
        check("br_retired", retired, 4);

        // jal then jr
        for (int i = 0; i < 5; i++) begin
            fetch(32'h0); issue();
        end
        check("jal_pc5", pc, 5);
        fetch(32'h0C00_0028);
        jal = 1'b1;
        issue();
        check("jal_pc", pc, 40);
        check("jal_we", link_we, 1);
        check("jal_data", link_data, 6);
        tick();
        check("jal_we_once", link_we, 0);
        check("jal_data_hold", link_data, 6);
        fetch(32'h03E0_0008);
        jr        = 1'b1;
        jr_target = 32'd6;
        issue();
        check("jr_pc", pc, 6);
        check("jr_we", link_we, 0);
        check("jr_data_hold", link_data, 6);

        // Trap (with branch also high) and eret
        for (int i = 0; i < 3; i++) begin
            fetch(32'h0); issue();
        end
        check("trap_pc9", pc, 9);
        check("trap_ret_before", retired, 14);
        fetch(32'h0);
        trap         = 1'b1;
        branch_taken = 1'b1;
        imm_ext      = 32'd5;
        issue();
        check("trap_pc", pc, 32'h20);
        check("trap_epc", epc, 9);
        check("trap_retired", retired, 14);
        fetch(32'h4200_0018);
        eret = 1'b1;
        issue();
        check("eret_pc", pc, 9);
        check("eret_retired", retired, 15);
        check("eret_epc_hold", epc, 9);

        // Controls ignored while exec_done is low
        fetch(32'h0800_0033);
        jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_pc%0d", i), pc, 9);
            check($sformatf("hold_valid%0d", i), instr_valid, 1);
        end
        jump = 1'b0;
        issue();
        check("hold_seq_pc", pc, 10);

        // eret outranks jal and jr; no link strobe
        fetch(32'h0C00_0077);
        eret      = 1'b1;
        jal       = 1'b1;
        jr        = 1'b1;
        jr_target = 32'd100;
        issue();
        check("prio_pc", pc, 9);
        check("prio_we", link_we, 0);
        check("prio_retired", retired, 17);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
